// File: rtl/fila_arbiter.sv
// Two-producer / one-consumer front end for an external 8-deep byte queue.
// Round-robin arbitration by default; define FILA_ARB_STRICT_PRIO_EN for fixed A-over-B priority.
module fila_arbiter (
  input  logic       clk_10KHz,
  input  logic       reset,
  input  logic       req_a,
  input  logic [7:0] data_a,
  input  logic       req_b,
  input  logic [7:0] data_b,
  input  logic       deq_req,
  output logic       grant_a,
  output logic       grant_b,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       busy,
  output logic [7:0] q_data_in,
  output logic       q_enqueue,
  output logic       q_dequeue,
  input  logic [7:0] q_data_out,
  input  logic [3:0] q_len
);

  typedef enum logic [1:0] {IDLE, ENQ, DEQ, CAPTURE} state_t;

  state_t     state_reg, state_next;
  logic       grant_a_next, grant_b_next;
  logic       q_enqueue_next, q_dequeue_next;
  logic       data_valid_next, busy_next;
  logic [7:0] q_data_in_next, data_out_next;
  logic       pick_b;

`ifdef FILA_ARB_STRICT_PRIO_EN
  assign pick_b = req_b && !req_a;
`else
  // prio_b_reg set means B was not the most recent winner and takes a tie.
  logic prio_b_reg, prio_b_next;
  assign pick_b = req_b && (!req_a || prio_b_reg);
`endif

  // Outputs are computed one cycle early so every pulse coincides with its state.
  always_comb begin
    state_next      = state_reg;
    grant_a_next    = 1'b0;
    grant_b_next    = 1'b0;
    q_enqueue_next  = 1'b0;
    q_dequeue_next  = 1'b0;
    data_valid_next = 1'b0;
    q_data_in_next  = q_data_in;
    data_out_next   = data_out;
`ifndef FILA_ARB_STRICT_PRIO_EN
    prio_b_next     = prio_b_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (deq_req && (q_len != 4'd0)) begin
          state_next     = DEQ;
          q_dequeue_next = 1'b1;
        end else if ((req_a || req_b) && (q_len < 4'd8)) begin
          state_next     = ENQ;
          q_enqueue_next = 1'b1;
          if (pick_b) begin
            grant_b_next   = 1'b1;
            q_data_in_next = data_b;
`ifndef FILA_ARB_STRICT_PRIO_EN
            prio_b_next    = 1'b0;
`endif
          end else begin
            grant_a_next   = 1'b1;
            q_data_in_next = data_a;
`ifndef FILA_ARB_STRICT_PRIO_EN
            prio_b_next    = 1'b1;
`endif
          end
        end
      end
      ENQ: state_next = IDLE;
      DEQ: state_next = CAPTURE;
      CAPTURE: begin
        state_next      = IDLE;
        data_out_next   = q_data_out;
        data_valid_next = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk_10KHz) begin
    if (reset) begin
      state_reg  <= IDLE;
      grant_a    <= 1'b0;
      grant_b    <= 1'b0;
      q_enqueue  <= 1'b0;
      q_dequeue  <= 1'b0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      q_data_in  <= 8'h00;
      data_out   <= 8'h00;
`ifndef FILA_ARB_STRICT_PRIO_EN
      prio_b_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      grant_a    <= grant_a_next;
      grant_b    <= grant_b_next;
      q_enqueue  <= q_enqueue_next;
      q_dequeue  <= q_dequeue_next;
      data_valid <= data_valid_next;
      busy       <= busy_next;
      q_data_in  <= q_data_in_next;
      data_out   <= data_out_next;
`ifndef FILA_ARB_STRICT_PRIO_EN
      prio_b_reg <= prio_b_next;
`endif
    end
  end

endmodule
